write_buffer: RTL and testbench

Posted write buffer between the data cache's dirty-line writeback path and the memory arbiter's write master port. It accepts whole-line writebacks in one cycle, queues up to DEPTH lines, and drains them in order as AXI write bursts (AW, then W beats, then B). It also gives the cache a snoop port, so a read miss to a line that is still buffered is detected and is either stalled or forwarded, depending on configuration.

---
 rtl/write_buffer_pkg.sv | 27 ++
 rtl/write_buffer_store.sv | 76 +++++++
 rtl/write_buffer.sv | 111 +++++++++++
 tb/tb_write_buffer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_buffer_pkg.sv
// Shared types and LINE_WORDS-derived widths for the posted write buffer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package write_buffer_pkg;

  localparam int WB_ADDR_W         = `ADDR_WIDTH;
  localparam int WB_LINE_WORDS     = 4;
  localparam int WB_BLOCK_OFFSET_W = $clog2(WB_LINE_WORDS);
  localparam int WB_LINE_ADDR_W    = WB_ADDR_W - 2 - WB_BLOCK_OFFSET_W;
  localparam int WB_LINE_DATA_W    = 32 * WB_LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic                      valid;
    logic [WB_LINE_ADDR_W-1:0] line_addr;
    logic [WB_LINE_DATA_W-1:0] line_data;
  } wb_entry_t;

endpackage

// File: rtl/write_buffer_store.sv
// Circular line FIFO with push/pop plus a snoop CAM where the youngest match wins.
// WRITE_BUFFER_FWD_EN adds the matching line's data to the snoop result.
module write_buffer_store
  import write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [WB_LINE_ADDR_W-1:0] push_addr_i,
  input  logic [WB_LINE_DATA_W-1:0] push_data_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [WB_LINE_ADDR_W-1:0] head_addr_o,
  output logic [WB_LINE_DATA_W-1:0] head_data_o,
  input  logic [WB_LINE_ADDR_W-1:0] snoop_addr_i,
  output logic                      snoop_hit_o
`ifdef WRITE_BUFFER_FWD_EN
  ,
  output logic [WB_LINE_DATA_W-1:0] snoop_data_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        entries_q[tail_q] <= '{valid: 1'b1, line_addr: push_addr_i, line_data: push_data_i};
        tail_q            <= tail_q + 1'b1;
      end
      if (pop_i) begin
        entries_q[head_q].valid <= 1'b0;
        head_q                  <= head_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_addr_o = entries_q[head_q].line_addr;
  assign head_data_o = entries_q[head_q].line_data;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    snoop_hit_o = 1'b0;
    idx         = '0;
`ifdef WRITE_BUFFER_FWD_EN
    snoop_data_o = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (entries_q[idx].valid && (entries_q[idx].line_addr == snoop_addr_i)) begin
        snoop_hit_o = 1'b1;
`ifdef WRITE_BUFFER_FWD_EN
        snoop_data_o = entries_q[idx].line_data;
`endif
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Posted write buffer draining dirty lines as in-order AXI bursts (AW, W beats, B).
// WRITE_BUFFER_FWD_EN exposes snoop_data for read-miss forwarding; otherwise the cache stalls on snoop_hit.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter int         LINE_WORDS = WB_LINE_WORDS,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_req_valid,
  output logic                      wb_req_ready,
  input  logic [WB_LINE_ADDR_W-1:0] wb_req_addr,
  input  logic [WB_LINE_DATA_W-1:0] wb_req_data,
  input  logic [WB_LINE_ADDR_W-1:0] snoop_addr,
  output logic                      snoop_hit,
`ifdef WRITE_BUFFER_FWD_EN
  output logic [WB_LINE_DATA_W-1:0] snoop_data,
`endif
  output logic                      wb_empty,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [3:0]                AWID,
  output logic [3:0]                AWLEN,
  output logic [WB_ADDR_W-1:0]      AWADDR,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic                      WLAST,
  output logic [3:0]                WID,
  output logic [31:0]               WDATA,
  input  logic                      BVALID,
  output logic                      BREADY,
  input  logic [3:0]                BID
);

  localparam logic [WB_BLOCK_OFFSET_W-1:0] LAST_BEAT = WB_BLOCK_OFFSET_W'(LINE_WORDS - 1);

  wb_state_t                      state_q, state_d;
  logic [WB_BLOCK_OFFSET_W-1:0]   beat_q, beat_d;
  logic                           push, pop, full, empty;
  logic [WB_LINE_ADDR_W-1:0]      head_addr;
  logic [WB_LINE_DATA_W-1:0]      head_data;

  assign wb_req_ready = !full && !rst;
  assign push         = wb_req_valid && wb_req_ready;

  write_buffer_store #(.DEPTH(DEPTH)) u_store (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_addr_i  (wb_req_addr),
    .push_data_i  (wb_req_data),
    .pop_i        (pop),
    .full_o       (full),
    .empty_o      (empty),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .snoop_addr_i (snoop_addr),
    .snoop_hit_o  (snoop_hit)
`ifdef WRITE_BUFFER_FWD_EN
    ,
    .snoop_data_o (snoop_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // A push into an empty buffer starts the burst on the next cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (!empty || push) state_d = ADDR;
      ADDR: if (AWREADY) begin
        state_d = DATA;
        beat_d  = '0;
      end
      DATA: if (WREADY) begin
        if (beat_q == LAST_BEAT) state_d = RESP;
        beat_d = beat_q + 1'b1;
      end
      RESP: if (BVALID && (BID == AXI_ID)) begin
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_empty = empty && (state_q == IDLE);
  assign AWVALID  = (state_q == ADDR);
  assign AWID     = AXI_ID;
  assign AWLEN    = 4'(LINE_WORDS - 1);
  assign AWADDR   = {head_addr, {(WB_BLOCK_OFFSET_W + 2){1'b0}}};
  assign WVALID   = (state_q == DATA);
  assign WLAST    = (state_q == DATA) && (beat_q == LAST_BEAT);
  assign WID      = AXI_ID;
  assign WDATA    = head_data[{beat_q, 5'b0} +: 32];
  assign BREADY   = (state_q == RESP);

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: directed literal scenarios plus randomized traffic against a queue model.
module tb_write_buffer;

  localparam int DEPTH = 4;
  localparam int LW    = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wb_req_valid = 1'b0;
  logic         wb_req_ready;
  logic [27:0]  wb_req_addr = '0;
  logic [127:0] wb_req_data = '0;
  logic [27:0]  snoop_addr = 28'h10;
  logic         snoop_hit;
`ifdef WRITE_BUFFER_FWD_EN
  logic [127:0] snoop_data;
`endif
  logic         wb_empty;
  logic         AWVALID, AWREADY = 1'b0;
  logic [3:0]   AWID, AWLEN;
  logic [31:0]  AWADDR;
  logic         WVALID, WREADY = 1'b0, WLAST;
  logic [3:0]   WID;
  logic [31:0]  WDATA;
  logic         BVALID = 1'b0, BREADY;
  logic [3:0]   BID = 4'd0;

  write_buffer dut (
    .clk(clk), .rst(rst),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_addr(wb_req_addr), .wb_req_data(wb_req_data),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
`ifdef WRITE_BUFFER_FWD_EN
    .snoop_data(snoop_data),
`endif
    .wb_empty(wb_empty),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: buffer contents as a queue plus progress of the head burst.
  typedef struct packed {
    logic [27:0]  addr;
    logic [127:0] data;
  } line_t;

  line_t mq[$];
  bit    m_aw_done = 1'b0;
  bit    m_gap     = 1'b0;
  int    m_beats   = 0;
  bit    started   = 1'b0;

  always @(negedge clk) begin
    logic         e_rdy, e_aw, e_w, e_b, e_hit, m_pop;
    logic [127:0] e_sd;
    if (started) begin
      e_rdy = !rst && (mq.size() < DEPTH);
      e_aw  = (mq.size() > 0) && !m_aw_done && !m_gap;
      e_w   = (mq.size() > 0) && m_aw_done && (m_beats < LW);
      e_b   = (mq.size() > 0) && m_aw_done && (m_beats == LW);
      e_hit = 1'b0;
      e_sd  = '0;
      foreach (mq[i]) if (mq[i].addr == snoop_addr) begin
        e_hit = 1'b1;
        e_sd  = mq[i].data;
      end
      chk("m_ready", wb_req_ready, e_rdy);
      chk("m_empty", wb_empty, mq.size() == 0);
      chk("m_awvalid", AWVALID, e_aw);
      chk("m_wvalid", WVALID, e_w);
      chk("m_wlast", WLAST, e_w && (m_beats == LW - 1));
      chk("m_bready", BREADY, e_b);
      chk("m_snoop_hit", snoop_hit, e_hit);
`ifdef WRITE_BUFFER_FWD_EN
      if (e_hit) chk("m_snoop_data", snoop_data, e_sd);
`endif
      if (e_aw) begin
        chk("m_awaddr", AWADDR, {mq[0].addr, 4'h0});
        chk("m_awlen", AWLEN, LW - 1);
        chk("m_awid", AWID, 0);
      end
      if (e_w) begin
        chk("m_wdata", WDATA, mq[0].data[m_beats*32 +: 32]);
        chk("m_wid", WID, 0);
      end
      if (rst) begin
        mq.delete();
        m_aw_done = 1'b0;
        m_beats   = 0;
        m_gap     = 1'b0;
      end else begin
        m_pop = e_b && BVALID && (BID == 4'd0);
        if (e_aw && AWREADY) m_aw_done = 1'b1;
        if (e_w && WREADY) m_beats++;
        if (m_pop) begin
          void'(mq.pop_front());
          m_aw_done = 1'b0;
          m_beats   = 0;
        end
        if (wb_req_valid && e_rdy) mq.push_back('{addr: wb_req_addr, data: wb_req_data});
        m_gap = m_pop;
      end
    end
  end

  task automatic wait_empty(input int lim, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!wb_empty && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(name, wb_empty, 1);
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] LINE1  = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] LINE_A = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] LINE_B = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;

  logic [31:0] words [8];
  logic        lasts [8];
  logic [31:0] aw_addrs [5];
  int          nb, done_k, acc_k, naw, k;

  initial begin
    // Reset
    @(posedge clk); #1;
    started = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", wb_req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", wb_req_ready, 1);
    chk("rst_empty", wb_empty, 1);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_wlast", WLAST, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_snoop_hit", snoop_hit, 0);

    // Single line, slave always ready
    @(posedge clk); #1;
    wb_req_valid = 1'b1; wb_req_addr = 28'h10; wb_req_data = LINE1;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BID = 4'd0;
    @(posedge clk); #1;
    wb_req_valid = 1'b0;
    nb = 0; done_k = 0;
    for (int kk = 1; kk <= 20 && done_k == 0; kk++) begin
      @(negedge clk);
      if (kk == 1) begin
        chk("t1_aw_next_cycle", AWVALID, 1);
        chk("t1_awaddr", AWADDR, 32'h100);
        chk("t1_awlen", AWLEN, 3);
      end
      if (WVALID && WREADY && nb < 8) begin
        words[nb] = WDATA;
        lasts[nb] = WLAST;
        nb++;
      end
      if (wb_empty) done_k = kk;
    end
    chk("t1_beats", nb, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t1_wdata%0d", j), words[j], j + 1);
      chk($sformatf("t1_wlast%0d", j), lasts[j], j == 3);
    end
    chk("t1_empty_cycle", done_k, 7);
    @(posedge clk); #1;

    // Fill to full with AW stalled, then drain in order
    AWREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_req_valid = 1'b1;
      wb_req_addr  = 28'(32'h20 + i);
      wb_req_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("t2_ready_enq%0d", i), wb_req_ready, i < 4);
      @(posedge clk); #1;
    end
    AWREADY = 1'b1;
    acc_k = -1; naw = 0;
    for (int kk = 0; kk < 100 && naw < 5; kk++) begin
      @(negedge clk);
      if (AWVALID && AWREADY) begin
        aw_addrs[naw] = AWADDR;
        naw++;
      end
      if (acc_k < 0 && wb_req_ready) acc_k = kk;
      @(posedge clk); #1;
      if (acc_k == kk) wb_req_valid = 1'b0;
    end
    chk("t2_accept_cycle", acc_k, 6);
    chk("t2_aw_count", naw, 5);
    for (int j = 0; j < 5; j++) chk($sformatf("t2_aw_order%0d", j), aw_addrs[j], 32'h200 + 32'h10 * j);
    wait_empty(100, "t2_drained");

    // Duplicate writebacks: youngest match wins
    AWREADY = 1'b0;
    wb_req_valid = 1'b1; wb_req_addr = 28'h10; wb_req_data = LINE_A;
    @(posedge clk); #1;
    wb_req_data = LINE_B;
    @(posedge clk); #1;
    wb_req_valid = 1'b0; snoop_addr = 28'h10;
    @(negedge clk);
    chk("t3_hit_dup", snoop_hit, 1);
`ifdef WRITE_BUFFER_FWD_EN
    chk("t3_data_youngest", snoop_data, LINE_B);
`endif
    @(posedge clk); #1;
    snoop_addr = 28'h11;
    @(negedge clk);
    chk("t3_miss", snoop_hit, 0);
    @(posedge clk); #1;

    // Mismatched BID is ignored
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BID = 4'd0; snoop_addr = 28'h10;
    k = 0;
    @(negedge clk);
    while (!BREADY && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("t4_reach_resp", BREADY, 1);
    @(posedge clk); #1;
    BVALID = 1'b1; BID = 4'd5;
    @(posedge clk); #1;
    BID = 4'd0;
    @(negedge clk);
    chk("t4_bid5_still_resp", BREADY, 1);
    chk("t4_bid5_still_hit", snoop_hit, 1);
    @(posedge clk); #1;
    BVALID = 1'b0;
    @(negedge clk);
    chk("t4_popped", BREADY, 0);
    chk("t4_idle_gap", AWVALID, 0);
    @(negedge clk);
    chk("t4_next_aw", AWVALID, 1);
    chk("t4_next_awaddr", AWADDR, 32'h100);
    @(posedge clk); #1;
    BVALID = 1'b1;
    wait_empty(50, "t4_drained");

    // Reset during beat 2
    BVALID = 1'b0;
    wb_req_valid = 1'b1; wb_req_addr = 28'h44; wb_req_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    wb_req_valid = 1'b0;
    nb = 0;
    for (int kk = 0; kk < 20 && nb < 2; kk++) begin
      @(negedge clk);
      if (WVALID && WREADY) nb++;
    end
    chk("t5_reach_beat2", nb, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_awvalid", AWVALID, 0);
    chk("t5_wvalid", WVALID, 0);
    chk("t5_wlast", WLAST, 0);
    chk("t5_bready", BREADY, 0);
    chk("t5_empty", wb_empty, 1);
    chk("t5_ready", wb_req_ready, 1);
    @(posedge clk); #1;
    wb_req_valid = 1'b1; wb_req_addr = 28'h45; BVALID = 1'b1;
    @(posedge clk); #1;
    wb_req_valid = 1'b0;
    @(negedge clk);
    chk("t5_new_aw", AWVALID, 1);
    chk("t5_new_awaddr", AWADDR, 32'h450);
    wait_empty(50, "t5_drained");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 399) == 0);
      wb_req_valid = ($urandom_range(0, 2) != 0);
      wb_req_addr  = 28'(32'h30 + $urandom_range(0, 3));
      wb_req_data  = {$urandom, $urandom, $urandom, $urandom};
      snoop_addr   = 28'(32'h30 + $urandom_range(0, 4));
      AWREADY      = ($urandom_range(0, 1) == 1);
      WREADY       = ($urandom_range(0, 2) != 0);
      BVALID       = ($urandom_range(0, 1) == 1);
      BID          = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      @(posedge clk); #1;
    end
    rst = 1'b0; wb_req_valid = 1'b0;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BID = 4'd0;
    wait_empty(200, "rand_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
